// File: rtl/max_reduce_tree_if.sv
// Beat input / batch result bundle for max_reduce_tree.
// The design takes the slave modport; a driver takes the master modport.
interface max_reduce_tree_if #(
  parameter int DATA_WIDTH = 12,
  parameter int LANES      = 64,
  parameter int POS_WIDTH  = 16
) ();
  localparam int LW = $clog2(LANES);

  logic                        init;
  logic                        in_valid;
  logic [DATA_WIDTH*LANES-1:0] in_data;
  logic [POS_WIDTH-1:0]        in_pos;
  logic                        in_last;
  logic [DATA_WIDTH-1:0]       run_max;
  logic [LW-1:0]               run_lane;
  logic [POS_WIDTH-1:0]        run_pos;
  logic                        done;
  logic [DATA_WIDTH-1:0]       res_max;
  logic [LW-1:0]               res_lane;
  logic [POS_WIDTH-1:0]        res_pos;

  modport master (
    output init, in_valid, in_data, in_pos, in_last,
    input  run_max, run_lane, run_pos, done, res_max, res_lane, res_pos
  );

  modport slave (
    input  init, in_valid, in_data, in_pos, in_last,
    output run_max, run_lane, run_pos, done, res_max, res_lane, res_pos
  );
endinterface

// File: rtl/max_reduce_tree.sv
// Pipelined pairwise max tree across LANES clamped scores, followed by a
// batch accumulator that reports the earliest strict maximum of each batch.
module max_reduce_tree #(
  parameter int  DATA_WIDTH = 12,
  parameter int  LANES      = 64,
  parameter int  POS_WIDTH  = 16,
  localparam int LW         = $clog2(LANES)
) (
  input logic              clk,
  input logic              rst,
  max_reduce_tree_if.slave bus
);

  // Level 0 is the combinational input; levels 1..LW are registered.
  for (genvar k = 0; k <= LW; k++) begin : lvl
    localparam int N = LANES >> k;
    logic [DATA_WIDTH-1:0] val  [N];
    logic [LW-1:0]         lane [N];
    logic [POS_WIDTH-1:0]  pos;
    logic                  last;
    logic                  vld;

    if (k == 0) begin : g_src
      // Negative scores enter the tree as zero, keeping their lane index.
      always_comb begin
        for (int i = 0; i < N; i++) begin
          if (bus.in_data[DATA_WIDTH*(i+1)-1]) begin
            val[i] = {DATA_WIDTH{1'b0}};
          end else begin
            val[i] = bus.in_data[DATA_WIDTH*i +: DATA_WIDTH];
          end
          lane[i] = LW'(i);
        end
      end

      assign pos  = bus.in_pos;
      assign last = bus.in_last;
      assign vld  = bus.in_valid & ~bus.init;
    end else begin : g_stage
      // Pairwise compare; the odd (higher) lane wins only when strictly larger.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) begin
            val[i]  <= {DATA_WIDTH{1'b0}};
            lane[i] <= {LW{1'b0}};
          end
          pos  <= {POS_WIDTH{1'b0}};
          last <= 1'b0;
          vld  <= 1'b0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (lvl[k-1].val[2*i+1] > lvl[k-1].val[2*i]) begin
              val[i]  <= lvl[k-1].val[2*i+1];
              lane[i] <= lvl[k-1].lane[2*i+1];
            end else begin
              val[i]  <= lvl[k-1].val[2*i];
              lane[i] <= lvl[k-1].lane[2*i];
            end
          end
          pos  <= lvl[k-1].pos;
          last <= lvl[k-1].last;
          vld  <= lvl[k-1].vld & ~bus.init;
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] tree_max_s;
  logic [LW-1:0]         tree_lane_s;
  logic [POS_WIDTH-1:0]  tree_pos_s;
  logic                  tree_last_s;
  logic                  tree_vld_s;

  assign tree_max_s  = lvl[LW].val[0];
  assign tree_lane_s = lvl[LW].lane[0];
  assign tree_pos_s  = lvl[LW].pos;
  assign tree_last_s = lvl[LW].last;
  assign tree_vld_s  = lvl[LW].vld;

  logic [DATA_WIDTH-1:0] run_max_r;
  logic [LW-1:0]         run_lane_r;
  logic [POS_WIDTH-1:0]  run_pos_r;
  logic [DATA_WIDTH-1:0] res_max_r;
  logic [LW-1:0]         res_lane_r;
  logic [POS_WIDTH-1:0]  res_pos_r;
  logic                  pend_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] base_max_s;
  logic                  take_s;

  // While the previous batch is being closed out, a new result competes against zero.
  always_comb begin
    base_max_s = run_max_r;
    take_s     = 1'b0;
    if (pend_r) begin
      base_max_s = {DATA_WIDTH{1'b0}};
    end else begin
      base_max_s = run_max_r;
    end
    take_s = tree_vld_s && (tree_max_s > base_max_s);
  end

  // Running maximum, batch close-out and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max_r  <= {DATA_WIDTH{1'b0}};
      run_lane_r <= {LW{1'b0}};
      run_pos_r  <= {POS_WIDTH{1'b0}};
      res_max_r  <= {DATA_WIDTH{1'b0}};
      res_lane_r <= {LW{1'b0}};
      res_pos_r  <= {POS_WIDTH{1'b0}};
      pend_r     <= 1'b0;
      done_r     <= 1'b0;
    end else if (bus.init) begin
      run_max_r  <= {DATA_WIDTH{1'b0}};
      run_lane_r <= {LW{1'b0}};
      run_pos_r  <= {POS_WIDTH{1'b0}};
      pend_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= pend_r;
      pend_r <= tree_vld_s & tree_last_s;
      if (pend_r) begin
        res_max_r  <= run_max_r;
        res_lane_r <= run_lane_r;
        res_pos_r  <= run_pos_r;
      end else begin
        res_max_r  <= res_max_r;
        res_lane_r <= res_lane_r;
        res_pos_r  <= res_pos_r;
      end
      if (take_s) begin
        run_max_r  <= tree_max_s;
        run_lane_r <= tree_lane_s;
        run_pos_r  <= tree_pos_s;
      end else if (pend_r) begin
        run_max_r  <= {DATA_WIDTH{1'b0}};
        run_lane_r <= {LW{1'b0}};
        run_pos_r  <= {POS_WIDTH{1'b0}};
      end else begin
        run_max_r  <= run_max_r;
        run_lane_r <= run_lane_r;
        run_pos_r  <= run_pos_r;
      end
    end
  end

  assign bus.run_max  = run_max_r;
  assign bus.run_lane = run_lane_r;
  assign bus.run_pos  = run_pos_r;
  assign bus.done     = done_r;
  assign bus.res_max  = res_max_r;
  assign bus.res_lane = res_lane_r;
  assign bus.res_pos  = res_pos_r;

endmodule

// File: tb/tb_max_reduce_tree.sv
// Bench for max_reduce_tree: an 8-lane instance for directed vectors and
// corner sequences, a 64-lane instance for a randomized batch regression.
module tb_max_reduce_tree;
  localparam int DW  = 12;
  localparam int PW  = 16;
  localparam int L8  = 8;
  localparam int L64 = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max_reduce_tree_if #(.DATA_WIDTH(DW), .LANES(L8),  .POS_WIDTH(PW)) bus8  ();
  max_reduce_tree_if #(.DATA_WIDTH(DW), .LANES(L64), .POS_WIDTH(PW)) bus64 ();

  max_reduce_tree #(.DATA_WIDTH(DW), .LANES(L8),  .POS_WIDTH(PW)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  max_reduce_tree #(.DATA_WIDTH(DW), .LANES(L64), .POS_WIDTH(PW)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [8*DW-1:0] d;
    int pos;
    int emax;
    int elane;
    int epos;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] m;
    logic [5:0]    l;
    logic [PW-1:0] p;
  } res64_t;

  vec_t            tbl [7];
  res64_t          expq [$];
  logic [64*DW-1:0] bq [$];
  logic [PW-1:0]   pq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*DW-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                            input int a4, input int a5, input int a6, input int a7);
    int v [8];
    logic [8*DW-1:0] r;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < 8; i++) r[DW*i +: DW] = DW'(v[i]);
    return r;
  endfunction

  function automatic vec_t mk(input logic [8*DW-1:0] d, input int pos, input int emax,
                              input int elane, input int epos);
    vec_t v;
    v.d = d; v.pos = pos; v.emax = emax; v.elane = elane; v.epos = epos;
    return v;
  endfunction

  task automatic drive8(input logic [8*DW-1:0] d, input int pos, input logic last);
    bus8.in_valid = 1'b1;
    bus8.in_data  = d;
    bus8.in_pos   = PW'(pos);
    bus8.in_last  = last;
  endtask

  task automatic idle8();
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    bus8.in_data  = '0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (bus8.done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  // Reference: the batch result is the earliest (beat order, then lane order)
  // occurrence of the largest clamped score, or all-zero when that maximum is 0.
  task automatic expect_batch();
    int best;
    int bidx;
    int c;
    logic [64*DW-1:0] bits;
    logic [DW-1:0] raw;
    res64_t r;
    best = 0;
    bidx = -1;
    for (int b = 0; b < bq.size(); b++) begin
      bits = bq[b];
      for (int l = 0; l < L64; l++) begin
        raw = bits[DW*l +: DW];
        c = raw[DW-1] ? 0 : int'(raw);
        if (c > best) begin
          best = c;
          bidx = b * L64 + l;
        end
      end
    end
    if (bidx < 0) r = '0;
    else begin
      r.m = DW'(best);
      r.l = 6'(bidx % L64);
      r.p = pq[bidx / L64];
    end
    expq.push_back(r);
  endtask

  task automatic cycle64();
    res64_t e;
    step();
    if (bus64.done === 1'b1) begin
      if (expq.size() == 0) chk("r64_spurious_done", 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        chk("r64_res_max",  64'(bus64.res_max),  64'(e.m));
        chk("r64_res_lane", 64'(bus64.res_lane), 64'(e.l));
        chk("r64_res_pos",  64'(bus64.res_pos),  64'(e.p));
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd_lane(input int mode);
    if (mode == 0) return DW'(int'($urandom_range(0, 40)) - 20);
    else if (mode == 1) return DW'($urandom);
    else return DW'($urandom_range(2040, 4095));
  endfunction

  initial begin
    int n;
    int seen;
    int len;
    int mode;
    logic [64*DW-1:0] d64;

    rst = 1'b1;
    bus8.init = 1'b0;  idle8(); bus8.in_pos = '0;
    bus64.init = 1'b0; bus64.in_valid = 1'b0; bus64.in_data = '0;
    bus64.in_pos = '0; bus64.in_last = 1'b0;
    #12;
    chk("rst_done",     64'(bus8.done),     64'd0);
    chk("rst_run_max",  64'(bus8.run_max),  64'd0);
    chk("rst_run_pos",  64'(bus8.run_pos),  64'd0);
    chk("rst_res_max",  64'(bus8.res_max),  64'd0);
    chk("rst_res_lane", 64'(bus8.res_lane), 64'd0);
    chk("rst_res_pos",  64'(bus8.res_pos),  64'd0);
    chk("rst_r64_res",  64'(bus64.res_max), 64'd0);
    #10;
    rst = 1'b0;
    step();

    tbl[0] = mk(pack8(5, 9, 3, 9, 0, -1, 7, 2), 4, 9, 1, 4);
    tbl[1] = mk(pack8(-1, -5, -2048, -7, -3, -100, -1, -9), 7, 0, 0, 0);
    tbl[2] = mk(pack8(1, 2, 3, 4, 5, 6, 7, 2047), 100, 2047, 7, 100);
    tbl[3] = mk(pack8(-2048, 100, 100, -1, 100, 0, 0, 0), 65535, 100, 1, 65535);
    tbl[4] = mk(pack8(0, 0, 0, 0, 0, 0, 0, 3), 9, 3, 7, 9);
    tbl[5] = mk(pack8(8, 8, 8, 8, 8, 8, 8, 8), 2, 8, 0, 2);
    tbl[6] = mk(pack8(0, 0, 0, 0, 0, 0, 0, 0), 5, 0, 0, 0);

    // Single-beat batches from the table.
    for (int t = 0; t < 7; t++) begin
      drive8(tbl[t].d, tbl[t].pos, 1'b1);
      step();
      idle8();
      wait_done8(n);
      chk($sformatf("vec%0d_latency", t),  64'(n),             64'd4);
      chk($sformatf("vec%0d_res_max", t),  64'(bus8.res_max),  64'(tbl[t].emax));
      chk($sformatf("vec%0d_res_lane", t), 64'(bus8.res_lane), 64'(tbl[t].elane));
      chk($sformatf("vec%0d_res_pos", t),  64'(bus8.res_pos),  64'(tbl[t].epos));
      step();
      chk($sformatf("vec%0d_done_pulse", t), 64'(bus8.done),    64'd0);
      chk($sformatf("vec%0d_run_clear", t),  64'(bus8.run_max), 64'd0);
    end

    // Three back-to-back beats; equal later maximum must not replace earlier.
    drive8(pack8(0, 1, 7, 2, 0, 0, 0, 0), 1, 1'b0); step();
    drive8(pack8(3, 0, 0, 0, 0, 11, 0, 0), 2, 1'b0); step();
    drive8(pack8(11, 0, 0, 0, 0, 0, 0, 0), 3, 1'b1); step();
    idle8();
    wait_done8(n);
    chk("b2b_latency",  64'(n),             64'd4);
    chk("b2b_res_max",  64'(bus8.res_max),  64'd11);
    chk("b2b_res_lane", 64'(bus8.res_lane), 64'd5);
    chk("b2b_res_pos",  64'(bus8.res_pos),  64'd2);
    step();
    chk("b2b_run_clear", 64'(bus8.run_max), 64'd0);
    chk("b2b_done_low",  64'(bus8.done),    64'd0);

    // Two one-beat batches on consecutive cycles.
    drive8(pack8(0, 6, 0, 0, 0, 0, 0, 0), 10, 1'b1); step();
    drive8(pack8(0, 0, 4, 0, 0, 0, 0, 0), 11, 1'b1); step();
    idle8();
    wait_done8(n);
    chk("pair_latency",  64'(n),            64'd3);
    chk("pair_first",    64'(bus8.res_max), 64'd6);
    step();
    chk("pair_done2",    64'(bus8.done),    64'd1);
    chk("pair_second",   64'(bus8.res_max), 64'd4);
    chk("pair_pos2",     64'(bus8.res_pos), 64'd11);

    // init mid-batch: flush accumulator and in-flight beat, discard same-cycle beat.
    drive8(pack8(0, 9, 0, 0, 0, 0, 0, 0), 20, 1'b0); step();
    idle8();
    repeat (4) step();
    chk("init_pre_run",  64'(bus8.run_max),  64'd9);
    chk("init_pre_pos",  64'(bus8.run_pos),  64'd20);
    drive8(pack8(12, 0, 0, 0, 0, 0, 0, 0), 21, 1'b0); step();
    idle8(); step();
    bus8.init = 1'b1;
    drive8(pack8(50, 0, 0, 0, 0, 0, 0, 0), 22, 1'b1); step();
    bus8.init = 1'b0;
    idle8();
    chk("init_run_clear", 64'(bus8.run_max), 64'd0);
    seen = 0;
    repeat (10) begin
      step();
      if (bus8.done === 1'b1) seen = 1;
    end
    chk("init_no_done",   64'(seen),          64'd0);
    chk("init_run_stay0", 64'(bus8.run_max),  64'd0);
    chk("init_res_max",   64'(bus8.res_max),  64'd4);
    chk("init_res_lane",  64'(bus8.res_lane), 64'd2);
    chk("init_res_pos",   64'(bus8.res_pos),  64'd11);
    drive8(pack8(0, 0, 0, 3, 0, 0, 0, 0), 23, 1'b1); step();
    idle8();
    wait_done8(n);
    chk("init_next_lat",  64'(n),             64'd4);
    chk("init_next_max",  64'(bus8.res_max),  64'd3);
    chk("init_next_lane", 64'(bus8.res_lane), 64'd3);

    // Asynchronous reset pulse between edges mid-batch.
    drive8(pack8(0, 0, 0, 0, 15, 0, 0, 0), 30, 1'b0); step();
    idle8();
    repeat (4) step();
    chk("arst_pre_run", 64'(bus8.run_max), 64'd15);
    drive8(pack8(1, 0, 0, 0, 0, 0, 0, 0), 31, 1'b1); step();
    idle8(); step();
    #3 rst = 1'b1;
    #1;
    chk("arst_run_max",  64'(bus8.run_max),  64'd0);
    chk("arst_run_lane", 64'(bus8.run_lane), 64'd0);
    chk("arst_run_pos",  64'(bus8.run_pos),  64'd0);
    chk("arst_res_max",  64'(bus8.res_max),  64'd0);
    chk("arst_res_pos",  64'(bus8.res_pos),  64'd0);
    chk("arst_done",     64'(bus8.done),     64'd0);
    #1 rst = 1'b0;
    drive8(pack8(0, 0, 0, 0, 0, 0, 21, 0), 32, 1'b1); step();
    idle8();
    wait_done8(n);
    chk("arst_next_lat",  64'(n),             64'd4);
    chk("arst_next_max",  64'(bus8.res_max),  64'd21);
    chk("arst_next_lane", 64'(bus8.res_lane), 64'd6);
    chk("arst_next_pos",  64'(bus8.res_pos),  64'd32);

    // Randomized 64-lane regression against the reference model.
    for (int b = 0; b < 60; b++) begin
      len = int'($urandom_range(1, 5));
      bq.delete();
      pq.delete();
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus64.in_valid = 1'b0;
          bus64.in_last  = 1'($urandom);
          bus64.in_data  = {24{32'($urandom)}};
          cycle64();
        end
        mode = int'($urandom_range(0, 2));
        for (int l = 0; l < L64; l++) d64[DW*l +: DW] = rnd_lane(mode);
        bus64.in_valid = 1'b1;
        bus64.in_data  = d64;
        bus64.in_pos   = PW'($urandom);
        bus64.in_last  = (j == len - 1);
        bq.push_back(d64);
        pq.push_back(bus64.in_pos);
        if (j == len - 1) expect_batch();
        cycle64();
      end
    end
    bus64.in_valid = 1'b0;
    bus64.in_last  = 1'b0;
    repeat (20) cycle64();
    chk("r64_all_done", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
